// File: rtl/flag_update_unit_if.sv
// Flags write-side bundle between the Execute stage and the NZCV flag update unit.
// master drives the stage/control requests; slave is the flag unit producing flags and gated enables.
interface flag_update_unit_if;
    logic       StallE;
    logic       FlushE;
    logic       CondExE;
    logic [1:0] FlagWriteE;
    logic [3:0] ALUFlagsE;
    logic       RegWriteE;
    logic       MemWriteE;
    logic       PCSrcE;
    logic       FlagLoad;
    logic [3:0] FlagLoadData;
    logic       FlagSave;
    logic       FlagRestore;
    logic [3:0] Flags;
    logic [3:0] SavedFlags;
    logic       RegWriteGated;
    logic       MemWriteGated;
    logic       PCSrcGated;
    logic       FlagsChanged;

    modport master (
        output StallE, FlushE, CondExE, FlagWriteE, ALUFlagsE,
               RegWriteE, MemWriteE, PCSrcE,
               FlagLoad, FlagLoadData, FlagSave, FlagRestore,
        input  Flags, SavedFlags, RegWriteGated, MemWriteGated, PCSrcGated, FlagsChanged
    );

    modport slave (
        input  StallE, FlushE, CondExE, FlagWriteE, ALUFlagsE,
               RegWriteE, MemWriteE, PCSrcE,
               FlagLoad, FlagLoadData, FlagSave, FlagRestore,
        output Flags, SavedFlags, RegWriteGated, MemWriteGated, PCSrcGated, FlagsChanged
    );
endinterface

// File: rtl/flag_update_unit.sv
// Execute-stage NZCV flag register with partial ALU updates, direct load and shadow save/restore.
// Optional FLAG_UPDATE_BYPASS_EN: Flags shows the NZCV next state (write-through) instead of the register.
module flag_update_unit #(
    parameter logic [3:0] RESET_FLAGS  = 4'b0000,
    parameter logic [3:0] SHADOW_RESET = 4'b0000
) (
    input  logic               clk,
    input  logic               reset,
    flag_update_unit_if.slave  fu
);

    logic [3:0] nzcv_q;
    logic [3:0] nzcv_d;
    logic [3:0] shadow_q;
    logic [3:0] alu_merged;
    logic       changed_q;
    logic       aluupd;
    logic       enable_ok;

    always_comb begin
        enable_ok = fu.CondExE & ~fu.FlushE;
        aluupd    = (|fu.FlagWriteE) & enable_ok & ~fu.StallE;

        // Unselected flag pairs keep their current register value.
        alu_merged[3:2] = fu.FlagWriteE[1] ? fu.ALUFlagsE[3:2] : nzcv_q[3:2];
        alu_merged[1:0] = fu.FlagWriteE[0] ? fu.ALUFlagsE[1:0] : nzcv_q[1:0];

        nzcv_d = nzcv_q;
        if (fu.FlagRestore)
            nzcv_d = shadow_q;
        else if (fu.FlagLoad)
            nzcv_d = fu.FlagLoadData;
        else if (aluupd)
            nzcv_d = alu_merged;
    end

    // NOTE: sequential state uses non-blocking assignments so that the shadow
    // samples the pre-edge nzcv_q, which is what makes save+restore a clean swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            nzcv_q    <= RESET_FLAGS;
            shadow_q  <= SHADOW_RESET;
            changed_q <= 1'b0;
        end else begin
            nzcv_q    <= nzcv_d;
            changed_q <= (nzcv_d != nzcv_q);
            if (fu.FlagSave)
                shadow_q <= nzcv_q;
        end
    end

    always_comb begin
        fu.RegWriteGated = fu.RegWriteE & enable_ok;
        fu.MemWriteGated = fu.MemWriteE & enable_ok;
        fu.PCSrcGated    = fu.PCSrcE    & enable_ok;
        fu.SavedFlags    = shadow_q;
        fu.FlagsChanged  = changed_q;
`ifdef FLAG_UPDATE_BYPASS_EN
        fu.Flags = nzcv_d;
`else
        fu.Flags = nzcv_q;
`endif
    end

endmodule

// File: tb/tb_flag_update_unit.sv
// Directed self-checking bench for flag_update_unit; expectations are hand-computed per scenario.
// Inputs change 1ns after the rising edge and outputs are compared 1ns later, away from the edge.
module tb_flag_update_unit;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    flag_update_unit_if fu ();

    flag_update_unit dut (
        .clk   (clk),
        .reset (reset),
        .fu    (fu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        fu.StallE       = 1'b0;
        fu.FlushE       = 1'b0;
        fu.CondExE      = 1'b0;
        fu.FlagWriteE   = 2'b00;
        fu.ALUFlagsE    = 4'b0000;
        fu.RegWriteE    = 1'b0;
        fu.MemWriteE    = 1'b0;
        fu.PCSrcE       = 1'b0;
        fu.FlagLoad     = 1'b0;
        fu.FlagLoadData = 4'b0000;
        fu.FlagSave     = 1'b0;
        fu.FlagRestore  = 1'b0;
    endtask

    // Clock the currently applied inputs in, then return to idle and let outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic load_flags(input logic [3:0] v);
        fu.FlagLoad     = 1'b1;
        fu.FlagLoadData = v;
        tick();
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        fu.FlagLoad     = 1'b1;
        fu.FlagLoadData = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        #1;
        vectors++;
        if (fu.Flags !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected %b", fu.Flags, 4'b0000);
            miscompares++;
        end
        vectors++;
        if (fu.SavedFlags !== 4'b0000) begin
            $display("FAIL reset_saved: got %b expected %b", fu.SavedFlags, 4'b0000);
            miscompares++;
        end
        vectors++;
        if (fu.FlagsChanged !== 1'b0) begin
            $display("FAIL reset_changed: got %b expected %b", fu.FlagsChanged, 1'b0);
            miscompares++;
        end
    endtask

    task automatic test_partial();
        fu.CondExE    = 1'b1;
        fu.FlagWriteE = 2'b10;
        fu.ALUFlagsE  = 4'b1111;
        tick();
        vectors++;
        if (fu.Flags !== 4'b1100) begin
            $display("FAIL partial_nz: got %b expected %b", fu.Flags, 4'b1100);
            miscompares++;
        end
        vectors++;
        if (fu.FlagsChanged !== 1'b1) begin
            $display("FAIL partial_nz_changed: got %b expected %b", fu.FlagsChanged, 1'b1);
            miscompares++;
        end
        fu.CondExE    = 1'b1;
        fu.FlagWriteE = 2'b01;
        fu.ALUFlagsE  = 4'b0010;
        tick();
        vectors++;
        if (fu.Flags !== 4'b1110) begin
            $display("FAIL partial_cv: got %b expected %b", fu.Flags, 4'b1110);
            miscompares++;
        end
    endtask

    task automatic test_gating();
        logic [2:0] gated;
        // Condition failed
        fu.FlagWriteE = 2'b11;
        fu.ALUFlagsE  = 4'b0101;
        fu.RegWriteE  = 1'b1;
        fu.MemWriteE  = 1'b1;
        fu.PCSrcE     = 1'b1;
        fu.CondExE    = 1'b0;
        #1;
        gated = {fu.RegWriteGated, fu.MemWriteGated, fu.PCSrcGated};
        vectors++;
        if (gated !== 3'b000) begin
            $display("FAIL condfail_gated: got %b expected %b", gated, 3'b000);
            miscompares++;
        end
        tick();
        vectors++;
        if (fu.Flags !== 4'b1110 || fu.FlagsChanged !== 1'b0) begin
            $display("FAIL condfail_flags: got %b/%b expected %b/%b", fu.Flags, fu.FlagsChanged, 4'b1110, 1'b0);
            miscompares++;
        end
        // Flushed
        fu.FlagWriteE = 2'b11;
        fu.ALUFlagsE  = 4'b0101;
        fu.RegWriteE  = 1'b1;
        fu.MemWriteE  = 1'b1;
        fu.PCSrcE     = 1'b1;
        fu.CondExE    = 1'b1;
        fu.FlushE     = 1'b1;
        #1;
        gated = {fu.RegWriteGated, fu.MemWriteGated, fu.PCSrcGated};
        vectors++;
        if (gated !== 3'b000) begin
            $display("FAIL flush_gated: got %b expected %b", gated, 3'b000);
            miscompares++;
        end
        tick();
        vectors++;
        if (fu.Flags !== 4'b1110) begin
            $display("FAIL flush_flags: got %b expected %b", fu.Flags, 4'b1110);
            miscompares++;
        end
        // Stalled: enables pass, flags hold
        fu.FlagWriteE = 2'b11;
        fu.ALUFlagsE  = 4'b0101;
        fu.RegWriteE  = 1'b1;
        fu.MemWriteE  = 1'b1;
        fu.PCSrcE     = 1'b1;
        fu.CondExE    = 1'b1;
        fu.StallE     = 1'b1;
        #1;
        gated = {fu.RegWriteGated, fu.MemWriteGated, fu.PCSrcGated};
        vectors++;
        if (gated !== 3'b111) begin
            $display("FAIL stall_gated: got %b expected %b", gated, 3'b111);
            miscompares++;
        end
        tick();
        vectors++;
        if (fu.Flags !== 4'b1110) begin
            $display("FAIL stall_flags: got %b expected %b", fu.Flags, 4'b1110);
            miscompares++;
        end
        // Individual enables with a passing condition, full update goes through
        fu.FlagWriteE = 2'b11;
        fu.ALUFlagsE  = 4'b0101;
        fu.RegWriteE  = 1'b0;
        fu.MemWriteE  = 1'b1;
        fu.PCSrcE     = 1'b0;
        fu.CondExE    = 1'b1;
        #1;
        gated = {fu.RegWriteGated, fu.MemWriteGated, fu.PCSrcGated};
        vectors++;
        if (gated !== 3'b010) begin
            $display("FAIL pass_gated: got %b expected %b", gated, 3'b010);
            miscompares++;
        end
        tick();
        vectors++;
        if (fu.Flags !== 4'b0101) begin
            $display("FAIL pass_flags: got %b expected %b", fu.Flags, 4'b0101);
            miscompares++;
        end
    endtask

    task automatic test_priority();
        fu.FlagLoad     = 1'b1;
        fu.FlagLoadData = 4'b0011;
        fu.CondExE      = 1'b1;
        fu.FlagWriteE   = 2'b11;
        fu.ALUFlagsE    = 4'b1100;
        tick();
        vectors++;
        if (fu.Flags !== 4'b0011) begin
            $display("FAIL load_over_alu: got %b expected %b", fu.Flags, 4'b0011);
            miscompares++;
        end
        load_flags(4'b1010);
        fu.FlagSave = 1'b1;
        tick();
        vectors++;
        if (fu.SavedFlags !== 4'b1010) begin
            $display("FAIL save_capture: got %b expected %b", fu.SavedFlags, 4'b1010);
            miscompares++;
        end
        load_flags(4'b0101);
        fu.FlagRestore  = 1'b1;
        fu.FlagLoad     = 1'b1;
        fu.FlagLoadData = 4'b0011;
        fu.CondExE      = 1'b1;
        fu.FlagWriteE   = 2'b11;
        fu.ALUFlagsE    = 4'b1100;
        tick();
        vectors++;
        if (fu.Flags !== 4'b1010) begin
            $display("FAIL restore_over_load: got %b expected %b", fu.Flags, 4'b1010);
            miscompares++;
        end
        // Stall does not block a direct load
        fu.StallE       = 1'b1;
        fu.FlagLoad     = 1'b1;
        fu.FlagLoadData = 4'b0111;
        tick();
        vectors++;
        if (fu.Flags !== 4'b0111) begin
            $display("FAIL load_under_stall: got %b expected %b", fu.Flags, 4'b0111);
            miscompares++;
        end
    endtask

    task automatic test_swap();
        load_flags(4'b0110);
        fu.FlagSave = 1'b1;
        tick();
        load_flags(4'b1001);
        fu.FlagSave    = 1'b1;
        fu.FlagRestore = 1'b1;
        tick();
        vectors++;
        if (fu.Flags !== 4'b0110) begin
            $display("FAIL swap_flags: got %b expected %b", fu.Flags, 4'b0110);
            miscompares++;
        end
        vectors++;
        if (fu.SavedFlags !== 4'b1001) begin
            $display("FAIL swap_saved: got %b expected %b", fu.SavedFlags, 4'b1001);
            miscompares++;
        end
        vectors++;
        if (fu.FlagsChanged !== 1'b1) begin
            $display("FAIL swap_changed: got %b expected %b", fu.FlagsChanged, 1'b1);
            miscompares++;
        end
        load_flags(4'b0110);
        vectors++;
        if (fu.FlagsChanged !== 1'b0) begin
            $display("FAIL same_value_changed: got %b expected %b", fu.FlagsChanged, 1'b0);
            miscompares++;
        end
    endtask

    task automatic test_reset_midop();
        reset           = 1'b1;
        fu.FlagSave     = 1'b1;
        fu.FlagRestore  = 1'b1;
        fu.FlagLoad     = 1'b1;
        fu.FlagLoadData = 4'b1011;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        #1;
        vectors++;
        if (fu.Flags !== 4'b0000 || fu.SavedFlags !== 4'b0000) begin
            $display("FAIL reset_midop: got %b/%b expected %b/%b", fu.Flags, fu.SavedFlags, 4'b0000, 4'b0000);
            miscompares++;
        end
    endtask

    task automatic test_bypass();
        logic [3:0] expect_now;
        load_flags(4'b0000);
        fu.CondExE    = 1'b1;
        fu.FlagWriteE = 2'b10;
        fu.ALUFlagsE  = 4'b0100;
        #1;
`ifdef FLAG_UPDATE_BYPASS_EN
        expect_now = 4'b0100;
`else
        expect_now = 4'b0000;
`endif
        vectors++;
        if (fu.Flags !== expect_now) begin
            $display("FAIL bypass_same_cycle: got %b expected %b", fu.Flags, expect_now);
            miscompares++;
        end
        tick();
        vectors++;
        if (fu.Flags !== 4'b0100) begin
            $display("FAIL bypass_next_cycle: got %b expected %b", fu.Flags, 4'b0100);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle();
        test_reset();
        test_partial();
        test_gating();
        test_priority();
        test_swap();
        test_reset_midop();
        test_bypass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
